// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares the single-ported data memory between the pipeline's MEM stage (CPU
// port) and a secondary requester such as a loader or debug DMA (DMA port).
// The block sits between the MEM-stage logic and the datamem instance. It
// steers address, data, enable and size lines to the memory, and it stalls
// the pipeline while the DMA port owns the memory.
//
// The DMA side uses a hold-until-ack handshake. A granted access completes on
// the granting edge. dma_ack is then high for exactly one cycle. No new grant
// is issued during that ack cycle, so DMA grants are at least two cycles apart.
//
// Optional feature (compile-time macro DMEM_ARB_STARVE_GUARD_EN):
//   When the macro is defined, a saturating counter tracks how many
//   consecutive cycles a pending DMA request has been denied. Once the count
//   reaches STARVE_LIMIT, the DMA preempts a busy CPU for one cycle.
//   When the macro is not defined, the DMA is granted only in CPU-idle cycles.
//
// Parameters:
//   STARVE_LIMIT   denied DMA cycles before preemption (guard build only), 1..15
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   cpu_read/cpu_write  MEM-stage load / store strobes
//   cpu_addr/cpu_wdata  MEM-stage address and forwarded store data
//   cpu_xfer_size       CPU transfer size
//   cpu_rdata           load data, combinational copy of mem_rdata
//   cpu_stall           CPU access present but not granted this cycle
//   dma_req/dma_we      DMA request (held until ack) and write select
//   dma_addr/dma_wdata  DMA access fields, stable while dma_req is high
//   dma_xfer_size       DMA transfer size
//   dma_ack             registered one-cycle completion pulse
//   dma_rdata           registered read data, valid while dma_ack is high
//   dma_grant           DMA owns the memory this cycle (combinational)
//   mem_*               memory-side drive; mem_rdata is the combinational read

module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [63:0] cpu_addr,
    input  logic [63:0] cpu_wdata,
    input  logic [3:0]  cpu_xfer_size,
    output logic [63:0] cpu_rdata,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [63:0] dma_addr,
    input  logic [63:0] dma_wdata,
    input  logic [3:0]  dma_xfer_size,
    output logic        dma_ack,
    output logic [63:0] dma_rdata,
    output logic        dma_grant,

    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [3:0]  mem_xfer_size,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [63:0] mem_rdata
);

    // Reject an out-of-range limit at elaboration time. A 4-bit counter
    // cannot reach a limit above 15, and a limit of 0 would preempt every cycle.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [0:0] {
        StIdle,
        StAck
    } dma_state_e;

    dma_state_e  state_q;
    logic        dma_ack_q;
    logic [63:0] dma_rdata_q;

    logic cpu_busy;
    logic starve_hit;
    logic grant;

    assign cpu_busy = cpu_read | cpu_write;

    // The reset term keeps the grant, and everything derived from it, low
    // while reset is high.
    assign grant = !reset && (state_q == StIdle) && dma_req && (!cpu_busy || starve_hit);

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LimitCnt = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;

    assign starve_hit = (starve_cnt_q == LimitCnt);

    // The count is held, not cleared, during the ack cycle. A request held
    // through ACK therefore keeps its accumulated wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else if (!dma_req || grant) begin
            starve_cnt_q <= 4'd0;
        end else if ((state_q == StIdle) && (starve_cnt_q != LimitCnt)) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // DMA handshake FSM. The access completes on the granting edge. The ack
    // and the captured read data are registered here, alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            dma_ack_q   <= 1'b0;
            dma_rdata_q <= 64'd0;
        end else begin
            dma_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_q   <= StAck;
                        dma_ack_q <= 1'b1;
                        if (!dma_we) begin
                            dma_rdata_q <= mem_rdata;
                        end
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Memory-side steering. A stalled CPU access is not forwarded; the
    // pipeline replays it in a later cycle. Simultaneous cpu_read and
    // cpu_write are illegal, and both enables pass through unchanged.
    always_comb begin
        mem_addr      = 64'd0;
        mem_wdata     = 64'd0;
        mem_xfer_size = 4'd0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        if (!reset) begin
            if (grant) begin
                mem_addr      = dma_addr;
                mem_wdata     = dma_wdata;
                mem_xfer_size = dma_xfer_size;
                mem_we        = dma_we;
                mem_re        = !dma_we;
            end else begin
                mem_addr      = cpu_addr;
                mem_wdata     = cpu_wdata;
                mem_xfer_size = cpu_xfer_size;
                mem_we        = cpu_write;
                mem_re        = cpu_read;
            end
        end
    end

    assign dma_grant = grant;
    assign cpu_stall = cpu_busy && grant;
    assign cpu_rdata = mem_rdata;
    assign dma_ack   = dma_ack_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory between the pipeline's MEM stage (CPU port) and a secondary requester such as a loader or debug DMA (DMA port). It sits between the MEM-stage logic and the `datamem` instance. It steers address, data, enable and transfer-size lines to the memory and stalls the pipeline when the DMA port holds the memory. The DMA side uses a hold-until-ack handshake with a registered one-cycle acknowledge.

## Interface
- `STARVE_LIMIT`, 4 — consecutive denied DMA cycles before the DMA port preempts the CPU (used only with the guard macro); legal range 1..15.

- `clk` in 1 — single clock; all state updates on the rising edge.
- `reset` in 1 — asynchronous, active-high.
- `cpu_read` in 1 — MEM-stage load (MemtoReg).
- `cpu_write` in 1 — MEM-stage store (MemWrite).
- `cpu_addr` in 64 — MEM-stage address (ALU result).
- `cpu_wdata` in 64 — store data, already forwarded.
- `cpu_xfer_size` in 4 — transfer size.
- `cpu_rdata` out 64 — load data; combinational copy of `mem_rdata`.
- `cpu_stall` out 1 — CPU access present but not granted this cycle.
- `dma_req` in 1 — DMA access request; held until `dma_ack`.
- `dma_we` in 1 — 1 = write, 0 = read.
- `dma_addr` in 64, `dma_wdata` in 64, `dma_xfer_size` in 4 — DMA access fields; stable while `dma_req` is high.
- `dma_ack` out 1 — registered one-cycle completion pulse.
- `dma_rdata` out 64 — registered read data, valid while `dma_ack` is high.
- `dma_grant` out 1 — DMA owns the memory this cycle (combinational).
- `mem_addr` out 64, `mem_wdata` out 64, `mem_xfer_size` out 4, `mem_we` out 1, `mem_re` out 1 — memory-side drive.
- `mem_rdata` in 64 — memory read data (combinational read).

## Operation
- DMA state machine, two states:
  - IDLE → ACK when `dma_grant` is high at a clock edge.
  - ACK → IDLE unconditionally.
  - No DMA grant is issued while in ACK, so back-to-back DMA accesses are at least 2 cycles apart.
- `cpu_busy` = `cpu_read | cpu_write`.
- `dma_grant` = state==IDLE & `dma_req` & (!`cpu_busy` | starve_hit).
  - starve_hit = (starve_cnt == STARVE_LIMIT); it is constant 0 without the macro.
- Mux:
  - While `dma_grant` is high, `mem_*` come from the DMA port: `mem_we`=`dma_we`, `mem_re`=!`dma_we`.
  - Otherwise `mem_*` come from the CPU port: `mem_we`=`cpu_write`, `mem_re`=`cpu_read`.
- `cpu_stall` = `cpu_busy` & `dma_grant`.
  - When stalled, the CPU access is not forwarded; the pipeline replays it next cycle.
- DMA completion: on the granting edge, `dma_rdata` <= `mem_rdata` (reads only; unchanged on writes) and `dma_ack` <= 1. `dma_ack` <= 0 on every other edge.
- CPU read and write both high is illegal; the block forwards both enables unchanged.
- While `reset` is high, `mem_we`, `mem_re`, `dma_grant` and `cpu_stall` are forced to 0.

## Timing
- Reset values:
  - state IDLE, starve_cnt 0.
  - `dma_ack` 0, `dma_rdata` 0.
  - `cpu_rdata` follows `mem_rdata`.
  - All other outputs 0.
- CPU latency:
  - Loads: same cycle, combinational path.
  - Stores: commit at the next edge.
- DMA latency: `dma_ack` is high the cycle after the grant. Minimum request-to-ack is 1 cycle on an idle CPU.
- Requester rules:
  - Deassert `dma_req`, or present a new request, in the ack cycle.
  - A request held high through ACK is re-granted no earlier than the cycle after ACK.
- Reset asserted mid-access: outputs drop immediately, the write is suppressed, and no ack is issued.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - starve_cnt increments each cycle with state==IDLE & `dma_req` & !`dma_grant`, saturating at STARVE_LIMIT.
  - It clears on grant or when `dma_req` is low.
  - At STARVE_LIMIT the DMA preempts the CPU for one cycle and `cpu_stall` pulses.
- Undefined:
  - The counter is not built.
  - The DMA is granted only in cycles with `cpu_busy` = 0 and can starve indefinitely.

## Test plan
- Reset: hold `reset` for 2 cycles with `dma_req`=1 and `cpu_write`=1 → `mem_we`=0, `dma_ack`=0, `dma_rdata`=0, `cpu_stall`=0.
- CPU only: `cpu_write` addr 0x80 data 0x45 size 8, then `cpu_read` addr 0x80 → `cpu_rdata`=0x45, `cpu_stall` never high.
- DMA on idle CPU, read and write:
  - DMA write 0x1234 to 0x100, then DMA read of 0x100.
  - Each ack arrives 1 cycle after its grant; the read's `dma_rdata`=0x1234.
  - The grants are at least 2 cycles apart.
- Collision, guard off:
  - CPU busy for 10 cycles with `dma_req` held → no grant.
  - First grant in the first cycle with the CPU idle.
  - `cpu_stall` stays 0.
- Collision, guard on, STARVE_LIMIT=4:
  - CPU continuously busy → `dma_grant` and `cpu_stall` high on the 5th request cycle.
  - `dma_ack` follows on the next cycle.
  - The CPU store issued in the stall cycle is not written until replayed.
- Reset mid-access: assert `reset` in a DMA write grant cycle → no ack, memory at that address unchanged, state IDLE after release.
